// File: rtl/ysyx_25060170_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// ysyx_25060170_mem_arbiter_if
//
// Purpose : bundles every handshake/bus signal around the memory arbiter:
//           the fetch (if_*) channel, the load/store (ls_*) channel, the
//           memory-side req/gnt/rvalid bus (mem_*) and the bus_err pulse.
//
// Modports:
//   master - the arbiter's view. It owns the memory command (it is the bus
//            master towards memory) and answers the ifu/lsu requesters.
//   slave  - the surrounding system's view: ifu/lsu requesters plus the
//            memory bridge, i.e. everything the arbiter talks to.
//
// Parameters: ADDR_W address width, DATA_W data width (mask is DATA_W/8).
// ---------------------------------------------------------------------------
interface ysyx_25060170_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch channel
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_flush;
  logic                  if_ready;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  // Load/store channel
  logic                  ls_req;
  logic                  ls_wen;
  logic [ADDR_W-1:0]     ls_addr;
  logic [DATA_W-1:0]     ls_wdata;
  logic [DATA_W/8-1:0]   ls_wmask;
  logic                  ls_ready;
  logic                  ls_rvalid;
  logic [DATA_W-1:0]     ls_rdata;

  // Memory bus
  logic                  mem_req;
  logic                  mem_wen;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  // Timeout error pulse
  logic                  bus_err;

  modport master (
    input  if_req, if_addr, if_flush,
    input  ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_ready, if_rvalid, if_rdata,
    output ls_ready, ls_rvalid, ls_rdata,
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output bus_err
  );

  modport slave (
    output if_req, if_addr, if_flush,
    output ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_ready, if_rvalid, if_rdata,
    input  ls_ready, ls_rvalid, ls_rdata,
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  bus_err
  );
endinterface

// File: rtl/ysyx_25060170_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_25060170_mem_arbiter
//
// Purpose : shares the core's single memory port between instruction fetch
//           (IF) and load/store (LS). One transaction is outstanding at a
//           time: IDLE arbitrates and latches the winner's command, REQ
//           presents it on mem_* until mem_gnt, WAIT waits for mem_rvalid
//           (or forces an error response after TIMEOUT cycles), RESP pulses
//           the owner's *_rvalid for one cycle.
//
// Ports   :
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - ysyx_25060170_mem_arbiter_if.master (if_*, ls_*, mem_*, bus_err)
//
// Parameters:
//   ADDR_W  - address width
//   DATA_W  - data width; write mask is DATA_W/8 bits
//   TIMEOUT - WAIT cycles tolerated before an error response (8-bit counter)
//
// Configuration macro:
//   YSYX_25060170_ARB_RR_EN - defined: round-robin between IF and LS on
//                             simultaneous requests (rr_last register).
//                             undefined: fixed LS-over-IF priority.
//
// Timing  : *_ready is combinational in IDLE (0-cycle request->ready);
//           all other outputs are registered. mem_rvalid -> *_rvalid is one
//           cycle; minimum turnaround is IDLE, REQ, WAIT, RESP = 4 cycles.
// ---------------------------------------------------------------------------
module ysyx_25060170_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  ysyx_25060170_mem_arbiter_if.master        bus
);

  localparam int MASK_W = DATA_W / 8;

  // The timeout counter is fixed at 8 bits; TIMEOUT is truncated to fit.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_e               state_q;
  owner_e               owner_q;
  logic                 drop_q;      // in-flight fetch response is discarded
  logic [7:0]           cnt_q;       // cycles spent in WAIT
  logic [7:0]           cnt_d;

  logic                 mem_req_q;
  logic                 mem_wen_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_W-1:0]    mem_wdata_q;
  logic [MASK_W-1:0]    mem_wmask_q;

  logic                 if_rvalid_q;
  logic [DATA_W-1:0]    if_rdata_q;
  logic                 ls_rvalid_q;
  logic [DATA_W-1:0]    ls_rdata_q;
  logic                 bus_err_q;

  logic                 grant_if;
  logic                 grant_ls;
  logic                 flush_hit;
  logic                 timeout_hit;

  assign cnt_d       = cnt_q + 8'd1;
  // The counter would reach TIMEOUT on this WAIT cycle: give up now, so WAIT
  // lasts at most TIMEOUT cycles.
  assign timeout_hit = (cnt_d == TIMEOUT_CNT);
  // Flush only matters while a fetch is actually in flight.
  assign flush_hit   = bus.if_flush && (owner_q == OWN_IF);

  // -------------------------------------------------------------------------
  // Arbitration (combinational so the winner sees ready in the same cycle)
  // -------------------------------------------------------------------------
`ifdef YSYX_25060170_ARB_RR_EN
  owner_e rr_last_q;   // requester granted most recently

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if ((state_q == ST_IDLE) && !rst) begin
      if (bus.if_req && bus.ls_req) begin
        // Tie: the side that was not served last time goes first.
        grant_ls = (rr_last_q == OWN_IF);
        grant_if = (rr_last_q == OWN_LS);
      end else begin
        grant_ls = bus.ls_req;
        grant_if = bus.if_req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= OWN_IF;
    end else if (grant_ls) begin
      rr_last_q <= OWN_LS;
    end else if (grant_if) begin
      rr_last_q <= OWN_IF;
    end
  end
`else
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if ((state_q == ST_IDLE) && !rst) begin
      // LS first: an older instruction's access never waits behind a fetch.
      grant_ls = bus.ls_req;
      grant_if = bus.if_req && !bus.ls_req;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Transaction FSM with registered outputs
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the values from before this clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      drop_q      <= 1'b0;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      // Pulsed outputs default low; only the WAIT->RESP edge raises them.
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      bus_err_q   <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (grant_ls) begin
            owner_q     <= OWN_LS;
            mem_req_q   <= 1'b1;
            mem_wen_q   <= bus.ls_wen;
            mem_addr_q  <= bus.ls_addr;
            mem_wdata_q <= bus.ls_wdata;
            mem_wmask_q <= bus.ls_wmask;
            state_q     <= ST_REQ;
          end else if (grant_if) begin
            // Fetches are always reads with an empty mask.
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b1;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            state_q     <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (flush_hit) begin
            drop_q <= 1'b1;
          end
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            cnt_q     <= 8'd0;
            state_q   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (flush_hit) begin
            drop_q <= 1'b1;
          end
          if (bus.mem_rvalid || timeout_hit) begin
            // A real response wins over a timeout on the same cycle; a
            // timeout returns zero data and raises bus_err alongside rvalid.
            if (owner_q == OWN_LS) begin
              ls_rdata_q  <= bus.mem_rvalid ? bus.mem_rdata : '0;
              ls_rvalid_q <= 1'b1;
            end else begin
              if_rdata_q  <= bus.mem_rvalid ? bus.mem_rdata : '0;
              // A flush on this very cycle still counts as flushed.
              if_rvalid_q <= !(drop_q || bus.if_flush);
            end
            bus_err_q <= !bus.mem_rvalid;
            state_q   <= ST_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ST_RESP: begin
          // rvalid was raised on entry and is cleared by the default above;
          // drop is cleared as we re-enter IDLE.
          drop_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output wiring
  // -------------------------------------------------------------------------
  assign bus.if_ready  = grant_if;
  assign bus.ls_ready  = grant_ls;

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.ls_rdata  = ls_rdata_q;

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;

  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_ysyx_25060170_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25060170_mem_arbiter
//
// Self-checking bench for ysyx_25060170_mem_arbiter. Stimulus is issued as
// whole transactions (an "episode": arbitration cycle, REQ cycles until the
// grant, WAIT cycles until the response or timeout, RESP cycle). While it
// drives each cycle the bench works out, from the arbiter's transaction
// rules, what every output must be in that cycle; a single compare process
// checks the DUT against those expectations on every falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ysyx_25060170_mem_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int MW      = DW / 8;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_25060170_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ysyx_25060170_mem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and check task
  // -------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Expected outputs for the current cycle
  // -------------------------------------------------------------------------
  typedef struct {
    logic          if_ready;
    logic          ls_ready;
    logic          if_rvalid;
    logic          ls_rvalid;
    logic          bus_err;
    logic          mem_req;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
  } exp_t;

  exp_t          e;
  bit            exp_on = 1'b0;
  logic [DW-1:0] m_if_rdata;    // last data delivered to each owner
  logic [DW-1:0] m_ls_rdata;

  task automatic clear_exp();
    e.if_ready  = 1'b0;
    e.ls_ready  = 1'b0;
    e.if_rvalid = 1'b0;
    e.ls_rvalid = 1'b0;
    e.bus_err   = 1'b0;
    e.mem_req   = 1'b0;
    e.mem_wen   = 1'b0;
    e.mem_addr  = '0;
    e.mem_wdata = '0;
    e.mem_wmask = '0;
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      check("if_ready",  32'(bus.if_ready),  32'(e.if_ready));
      check("ls_ready",  32'(bus.ls_ready),  32'(e.ls_ready));
      check("if_rvalid", 32'(bus.if_rvalid), 32'(e.if_rvalid));
      check("ls_rvalid", 32'(bus.ls_rvalid), 32'(e.ls_rvalid));
      check("bus_err",   32'(bus.bus_err),   32'(e.bus_err));
      check("mem_req",   32'(bus.mem_req),   32'(e.mem_req));
      check("if_rdata",  bus.if_rdata,       m_if_rdata);
      check("ls_rdata",  bus.ls_rdata,       m_ls_rdata);
      if (e.mem_req) begin
        check("mem_wen",   32'(bus.mem_wen),   32'(e.mem_wen));
        check("mem_addr",  bus.mem_addr,       e.mem_addr);
        check("mem_wmask", 32'(bus.mem_wmask), 32'(e.mem_wmask));
        if (e.mem_wen) check("mem_wdata", bus.mem_wdata, e.mem_wdata);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Small observation monitor used by the literal pin checks
  // -------------------------------------------------------------------------
  int   cyc      = 0;
  int   t_if_rdy = -1;
  int   t_if_rv  = -1;
  int   err_cnt  = 0;
  logic last_win_ls = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.if_ready)  t_if_rdy = cyc;
      if (bus.if_rvalid) t_if_rv  = cyc;
      if (bus.bus_err)   err_cnt++;
      if (bus.if_ready || bus.ls_ready) last_win_ls = bus.ls_ready;
    end
  end

  // Runaway guard: never hang.
  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Requester state kept by the bench
  // -------------------------------------------------------------------------
  bit            if_pend, ls_pend;
  logic [AW-1:0] if_a, ls_a;
  logic          ls_w;
  logic [DW-1:0] ls_d;
  logic [MW-1:0] ls_m;
  bit            rr_last_ls;   // who was granted last (round-robin build)

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    if_pend    = 1'b0;
    ls_pend    = 1'b0;
    rr_last_ls = 1'b0;
    m_if_rdata = '0;
    m_ls_rdata = '0;
  endtask

  task automatic drive_quiet();
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.if_flush   = 1'b0;
    bus.ls_req     = 1'b0;
    bus.ls_wen     = 1'b0;
    bus.ls_addr    = '0;
    bus.ls_wdata   = '0;
    bus.ls_wmask   = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_ready"},  32'(bus.if_ready),  32'd0);
    check({tag, "_ls_ready"},  32'(bus.ls_ready),  32'd0);
    check({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
    check({tag, "_ls_rvalid"}, 32'(bus.ls_rvalid), 32'd0);
    check({tag, "_if_rdata"},  bus.if_rdata,       32'd0);
    check({tag, "_ls_rdata"},  bus.ls_rdata,       32'd0);
    check({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
    check({tag, "_mem_wen"},   32'(bus.mem_wen),   32'd0);
    check({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
    check({tag, "_mem_wmask"}, 32'(bus.mem_wmask), 32'd0);
    check({tag, "_bus_err"},   32'(bus.bus_err),   32'd0);
  endtask

  // -------------------------------------------------------------------------
  // One transaction. gnt_dly: REQ cycles without mem_gnt before the grant.
  // rsp_dly: WAIT cycles without mem_rvalid before the response (<0 means
  // never respond -> timeout). flush_cyc: index over the REQ+WAIT cycles at
  // which if_flush is forced (-1 none). noisy: random stray gnt/rvalid/flush
  // where they must have no effect. rst_mid: assert reset in the 2nd WAIT
  // cycle and abandon the transaction.
  // -------------------------------------------------------------------------
  task automatic episode(input int gnt_dly, input int rsp_dly, input int flush_cyc,
                         input logic [DW-1:0] data, input bit noisy, input bit rst_mid);
    bit win_ls, tmo, drop;
    int k, n;

    // Arbitration cycle
    clear_exp();
    bus.if_req     = if_pend;
    bus.if_addr    = if_a;
    bus.ls_req     = ls_pend;
    bus.ls_wen     = ls_w;
    bus.ls_addr    = ls_a;
    bus.ls_wdata   = ls_d;
    bus.ls_wmask   = ls_m;
    bus.mem_gnt    = noisy && ($urandom_range(0, 1) == 1);
    bus.mem_rvalid = noisy && ($urandom_range(0, 1) == 1);
    bus.mem_rdata  = $urandom;
    bus.if_flush   = noisy && ($urandom_range(0, 3) == 0);
    if (!if_pend && !ls_pend) begin
      step();
      return;
    end
`ifdef YSYX_25060170_ARB_RR_EN
    if (if_pend && ls_pend) win_ls = !rr_last_ls;
    else                    win_ls = ls_pend;
`else
    win_ls = ls_pend;
`endif
    rr_last_ls = win_ls;
    e.ls_ready = win_ls;
    e.if_ready = !win_ls;
    step();

    // Winner drops its request once accepted; the loser keeps holding.
    if (win_ls) begin ls_pend = 1'b0; bus.ls_req = 1'b0; end
    else        begin if_pend = 1'b0; bus.if_req = 1'b0; end

    // REQ phase
    e.if_ready  = 1'b0;
    e.ls_ready  = 1'b0;
    e.mem_req   = 1'b1;
    e.mem_wen   = win_ls ? ls_w : 1'b0;
    e.mem_addr  = win_ls ? ls_a : if_a;
    e.mem_wdata = ls_d;
    e.mem_wmask = win_ls ? ls_m : '0;
    drop = 1'b0;
    k    = 0;
    for (int i = 0; i <= gnt_dly; i++) begin
      bus.mem_gnt    = (i == gnt_dly);
      bus.mem_rvalid = noisy && ($urandom_range(0, 1) == 1);
      bus.mem_rdata  = $urandom;
      bus.if_flush   = (k == flush_cyc) || (noisy && ($urandom_range(0, 7) == 0));
      if (bus.if_flush && !win_ls) drop = 1'b1;
      k++;
      step();
    end

    // WAIT phase
    e.mem_req = 1'b0;
    tmo = (rsp_dly < 0);
    n   = tmo ? TIMEOUT : rsp_dly + 1;
    for (int i = 0; i < n; i++) begin
      bus.mem_rvalid = !tmo && (i == n - 1);
      bus.mem_rdata  = bus.mem_rvalid ? data : $urandom;
      bus.mem_gnt    = noisy && ($urandom_range(0, 1) == 1);
      bus.if_flush   = (k == flush_cyc) || (noisy && ($urandom_range(0, 7) == 0));
      if (bus.if_flush && !win_ls) drop = 1'b1;
      k++;
      if (rst_mid && i == 1) begin
        exp_on = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        drive_quiet();
        model_reset();
        rst = 1'b0;
        clear_exp();
        exp_on = 1'b1;
        return;
      end
      step();
    end

    // RESP cycle: stray memory activity and flushes here have no effect.
    bus.mem_rvalid = noisy || tmo;
    bus.mem_rdata  = $urandom;
    bus.mem_gnt    = noisy && ($urandom_range(0, 1) == 1);
    bus.if_flush   = noisy && ($urandom_range(0, 3) == 0);
    e.bus_err      = tmo;
    if (win_ls) begin
      e.ls_rvalid = 1'b1;
      m_ls_rdata  = tmo ? '0 : data;
    end else begin
      e.if_rvalid = !drop;
      m_if_rdata  = tmo ? '0 : data;
    end
    step();
    clear_exp();
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.if_flush   = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    int g, r, f;

    drive_quiet();
    model_reset();
    clear_exp();
    if_a = '0; ls_a = '0; ls_w = 1'b0; ls_d = '0; ls_m = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    exp_on = 1'b1;

    // Single fetch: gnt one cycle after ready, rvalid two cycles after gnt.
    if_pend = 1'b1;
    if_a    = 32'h8000_0000;
    episode(0, 1, -1, 32'h0000_0413, 1'b0, 1'b0);
    check("pin_fetch_rdata", bus.if_rdata, 32'h0000_0413);
    check("pin_fetch_ready_to_rvalid", 32'(t_if_rv - t_if_rdy), 32'd4);

    // Store.
    ls_pend = 1'b1; ls_w = 1'b1; ls_a = 32'h8000_1000; ls_d = 32'hDEAD_BEEF; ls_m = 4'hF;
    episode(1, 0, -1, 32'h0000_0000, 1'b0, 1'b0);

    // Contention: rr_last is now LS, so round-robin grants IF first.
    if_pend = 1'b1; if_a = 32'h8000_0004;
    ls_pend = 1'b1; ls_w = 1'b0; ls_a = 32'h8000_2000; ls_d = '0; ls_m = 4'h3;
    episode(0, 0, -1, 32'h1111_2222, 1'b0, 1'b0);
`ifdef YSYX_25060170_ARB_RR_EN
    check("pin_contention_first_ls", 32'(last_win_ls), 32'd0);
`else
    check("pin_contention_first_ls", 32'(last_win_ls), 32'd1);
`endif
    episode(0, 0, -1, 32'h3333_4444, 1'b0, 1'b0);

    // Flush in the first WAIT cycle of a fetch, then a load served normally.
    if_pend = 1'b1; if_a = 32'h8000_0008;
    episode(0, 2, 1, 32'h1234_5678, 1'b0, 1'b0);
    ls_pend = 1'b1; ls_w = 1'b0; ls_a = 32'h8000_3000; ls_m = 4'h1;
    episode(0, 0, -1, 32'h5555_6666, 1'b0, 1'b0);

    // Timeout on a load, then a stray mem_rvalid in IDLE.
    ls_pend = 1'b1; ls_w = 1'b0; ls_a = 32'h8000_4000; ls_m = 4'hF;
    episode(0, -1, -1, 32'h0, 1'b0, 1'b0);
    check("pin_timeout_err_pulses", 32'(err_cnt), 32'd1);
    check("pin_timeout_ls_rdata", bus.ls_rdata, 32'h0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0_BAD0;
    step();
    bus.mem_rvalid = 1'b0;

    // Reset in WAIT, then a fresh fetch is granted on the first cycle.
    if_pend = 1'b1; if_a = 32'h8000_0010;
    episode(0, 5, -1, 32'h0, 1'b0, 1'b1);
    if_pend = 1'b1; if_a = 32'h8000_0020;
    episode(0, 0, -1, 32'h7777_8888, 1'b0, 1'b0);

    // Randomised traffic with stray memory activity and flushes.
    for (int n = 0; n < 300; n++) begin
      if (!if_pend && $urandom_range(0, 2) != 0) begin
        if_pend = 1'b1;
        if_a    = $urandom;
      end
      if (!ls_pend && $urandom_range(0, 2) != 0) begin
        ls_pend = 1'b1;
        ls_w    = 1'($urandom_range(0, 1));
        ls_a    = $urandom;
        ls_d    = $urandom;
        ls_m    = 4'($urandom);
      end
      g = $urandom_range(0, 3);
      r = ($urandom_range(0, 39) == 0) ? -1 : int'($urandom_range(0, 4));
      f = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1;
      episode(g, r, f, $urandom, 1'b1, 1'b0);
    end

    exp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
